grp_bank_scheduler: RTL and testbench
=====================================

# grp_bank_scheduler

Ping-pong scheduler for the two 1024×12 group buffers between the frame filler (writer, clk80) and the M8 frame former (reader, clk12). It owns bank selection, steering each side's read/write strobes and the read-data mux to the correct bank. It swaps banks only when the writer has completed a page and the reader has reached a frame boundary. It also flags and counts overruns (writer too fast) and underruns (reader repeats a stale page).

## Interface
- ADDR_W, 10, bank address width
- DATA_W, 12, sample width
- SYNC_STAGES, 2, synchronizer depth for reader-domain strobes (min 2)
- CNT_W, 8, width of the saturating event counters
- clk80  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- rdEn  in  1  reader read enable (clk12 domain), routed combinationally to the active read bank
- rdAddr  in  ADDR_W  reader address, routed combinationally to both banks
- rdFrame  in  1  reader frame toggle (clk12 domain); each edge is one frame boundary
- rdData  out  DATA_W  read data, muxed from the bank selected one cycle earlier
- wrEn  in  1  writer write strobe
- wrDone  in  1  one-cycle pulse: writer finished the current page
- wrReady  out  1  writer may write; low while a finished page awaits swap
- bankRE0, bankRE1  out  1  bank read enables
- bankWE0, bankWE1  out  1  bank write enables
- readBank  out  1  bank currently being read (writer uses the other)
- swapPulse  out  1  one-cycle pulse on bank swap
- overrun, underrun  out  1  sticky flags, cleared only by reset
- overrunCnt, underrunCnt  out  CNT_W  saturating event counters

## Operation
- States: FILL (page open, wrReady=1), HOLD (page complete, wrReady=0), SWAP (one cycle; toggles readBank, pulses swapPulse, then goes to FILL).
- FILL→HOLD on wrDone. HOLD→SWAP on a synchronized rdFrame edge.
- Boundary in FILL: underrun. No swap; reader re-reads the same bank; underrun=1; underrunCnt+1.
- wrDone and boundary in the same FILL cycle: treated as a completed page; go directly to SWAP. No underrun.
- wrEn while wrReady=0 (HOLD or SWAP): the write is dropped (no bankWE). overrun=1; overrunCnt+1 once per held page, not per dropped write.
- wrDone in HOLD: ignored; counts as overrun under the same once-per-page rule.
- Steering: bankRE[readBank]=rdEn, the other bankRE=0. bankWE[~readBank]=wrEn&wrReady, the other bankWE=0. No bank is ever written and read-enabled in the same cycle.
- Counters saturate at 2^CNT_W−1.
- Reset values: state FILL, readBank=0, wrReady=1, swapPulse=0, rdData=0, flags=0, counters=0. Reset mid-page discards the page; the writer restarts into bank 1.

## Timing
- rdFrame passes through SYNC_STAGES flops plus one edge-detect flop. A boundary is recognized SYNC_STAGES+1 clk80 cycles after the toggle.
- HOLD→SWAP: one cycle after recognition. readBank changes on the clock edge that leaves SWAP. swapPulse is high during SWAP.
- rdData mux select is readBank delayed one clk80 cycle, matching the banks' one-cycle registered read latency.
- wrReady is registered and drops the cycle after wrDone. It rises the cycle after SWAP.
- Write/read strobe steering is combinational from registered readBank/wrReady; zero added latency.

## Configuration
- BANK_STATS_EN defined: overrunCnt/underrunCnt implemented as above.
- BANK_STATS_EN undefined: counters tied to 0 and no counter logic is built. Flags, state machine and steering are unchanged.

## Test plan
- After reset: readBank=0, wrReady=1, writes hit bankWE1 only, all counters 0, rdData=0.
- wrDone then rdFrame toggle: swapPulse one cycle at SYNC_STAGES+2 cycles after the toggle; readBank=1; writes now hit bank 0; reading address 5 returns the word written there.
- Two rdFrame toggles with no wrDone: underrunCnt=2, underrun=1, readBank stays 0.
- wrDone, then 10 wrEn pulses before any boundary: zero bankWE pulses, overrunCnt=1, overrun=1.
- wrDone in the same cycle as a recognized boundary in FILL: swap occurs, underrunCnt unchanged.
- 300 underruns: underrunCnt saturates at 255. With BANK_STATS_EN undefined, underrunCnt reads 0 and the underrun flag is 1.

Source files
------------

// File: rtl/grp_bank_scheduler.sv
// Ping-pong bank scheduler for the two group buffers between frame filler and M8 frame former.
// Optional macro BANK_STATS_EN builds the saturating overrun/underrun event counters.
module grp_bank_scheduler #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk80,
    input  logic              rst,
    // reader side
    input  logic              rdEn,
    input  logic [ADDR_W-1:0] rdAddr,
    input  logic              rdFrame,
    output logic [DATA_W-1:0] rdData,
    // writer side
    input  logic              wrEn,
    input  logic              wrDone,
    output logic              wrReady,
    // bank side
    output logic [ADDR_W-1:0] bankAddr,
    input  logic [DATA_W-1:0] bankRdData0,
    input  logic [DATA_W-1:0] bankRdData1,
    output logic              bankRE0,
    output logic              bankRE1,
    output logic              bankWE0,
    output logic              bankWE1,
    // status
    output logic              readBank,
    output logic              swapPulse,
    output logic              overrun,
    output logic              underrun,
    output logic [CNT_W-1:0]  overrunCnt,
    output logic [CNT_W-1:0]  underrunCnt
);

    typedef enum logic [1:0] {StFill, StHold, StSwap} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] frame_sync_q;
    logic                   frame_prev_q;
    logic                   bnd_q;
    logic                   read_bank_q;
    logic                   wr_ready_q;
    logic                   rd_sel_q;
    logic                   rd_vld_q;
    logic                   ovr_seen_q, ovr_seen_d;
    logic                   overrun_q;
    logic                   underrun_q;
    logic                   ovr_evt;
    logic                   unr_evt;

    // rdFrame crosses from clk12; boundary is a registered one-cycle pulse per toggle
    always_ff @(posedge clk80 or negedge rst) begin
        if (!rst) begin
            frame_sync_q <= '0;
            frame_prev_q <= 1'b0;
            bnd_q        <= 1'b0;
        end else begin
            frame_sync_q <= {frame_sync_q[SYNC_STAGES-2:0], rdFrame};
            frame_prev_q <= frame_sync_q[SYNC_STAGES-1];
            bnd_q        <= frame_sync_q[SYNC_STAGES-1] ^ frame_prev_q;
        end
    end

    always_comb begin
        state_d = state_q;
        ovr_evt = 1'b0;
        unr_evt = 1'b0;
        unique case (state_q)
            StFill: begin
                if (wrDone) begin
                    state_d = bnd_q ? StSwap : StHold;
                end else if (bnd_q) begin
                    unr_evt = 1'b1;
                end
            end
            StHold: begin
                if (bnd_q) begin
                    state_d = StSwap;
                end
                if ((wrEn || wrDone) && !ovr_seen_q) begin
                    ovr_evt = 1'b1;
                end
            end
            StSwap: begin
                state_d = StFill;
                if (wrEn && !ovr_seen_q) begin
                    ovr_evt = 1'b1;
                end
            end
            default: state_d = StFill;
        endcase
    end

    // One overrun event per held page; rearmed when a fresh page opens
    always_comb begin
        ovr_seen_d = ovr_seen_q;
        if (state_d == StFill) begin
            ovr_seen_d = 1'b0;
        end else if (ovr_evt) begin
            ovr_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk80 or negedge rst) begin
        if (!rst) begin
            state_q     <= StFill;
            read_bank_q <= 1'b0;
            wr_ready_q  <= 1'b1;
            rd_sel_q    <= 1'b0;
            rd_vld_q    <= 1'b0;
            ovr_seen_q  <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ready_q  <= (state_d == StFill);
            rd_sel_q    <= read_bank_q;
            rd_vld_q    <= rdEn;
            ovr_seen_q  <= ovr_seen_d;
            overrun_q   <= overrun_q | ovr_evt;
            underrun_q  <= underrun_q | unr_evt;
            if (state_q == StSwap) begin
                read_bank_q <= ~read_bank_q;
            end
        end
    end

`ifdef BANK_STATS_EN
    logic [CNT_W-1:0] ovr_cnt_q;
    logic [CNT_W-1:0] unr_cnt_q;

    always_ff @(posedge clk80 or negedge rst) begin
        if (!rst) begin
            ovr_cnt_q <= '0;
            unr_cnt_q <= '0;
        end else begin
            if (ovr_evt && (ovr_cnt_q != {CNT_W{1'b1}})) begin
                ovr_cnt_q <= ovr_cnt_q + 1'b1;
            end
            if (unr_evt && (unr_cnt_q != {CNT_W{1'b1}})) begin
                unr_cnt_q <= unr_cnt_q + 1'b1;
            end
        end
    end

    assign overrunCnt  = ovr_cnt_q;
    assign underrunCnt = unr_cnt_q;
`else
    assign overrunCnt  = '0;
    assign underrunCnt = '0;
`endif

    // Steering is combinational off registered state so strobes add no latency
    assign bankAddr  = rdAddr;
    assign bankRE0   = rdEn & ~read_bank_q;
    assign bankRE1   = rdEn & read_bank_q;
    assign bankWE0   = wrEn & wr_ready_q & read_bank_q;
    assign bankWE1   = wrEn & wr_ready_q & ~read_bank_q;

    // Read data is zero unless a read was issued the previous cycle
    assign rdData    = rd_vld_q ? (rd_sel_q ? bankRdData1 : bankRdData0) : '0;

    assign wrReady   = wr_ready_q;
    assign readBank  = read_bank_q;
    assign swapPulse = (state_q == StSwap);
    assign overrun   = overrun_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_grp_bank_scheduler.sv
// Directed bench for grp_bank_scheduler; models the two registered-read banks externally.
module tb_grp_bank_scheduler;

`ifdef BANK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk80 = 1'b0;
    logic        rst = 1'b0;
    logic        rdEn = 1'b0;
    logic [9:0]  rdAddr = '0;
    logic        rdFrame = 1'b0;
    logic [11:0] rdData;
    logic        wrEn = 1'b0;
    logic        wrDone = 1'b0;
    logic        wrReady;
    logic [9:0]  bankAddr;
    logic [11:0] bankRdData0 = '0;
    logic [11:0] bankRdData1 = '0;
    logic        bankRE0, bankRE1, bankWE0, bankWE1;
    logic        readBank, swapPulse, overrun, underrun;
    logic [7:0]  overrunCnt, underrunCnt;

    logic [9:0]  wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic [11:0] mem0 [1024];
    logic [11:0] mem1 [1024];
    int          we0_n = 0;
    int          we1_n = 0;
    int          checks = 0;
    int          errors = 0;

    always #6 clk80 = ~clk80;

    grp_bank_scheduler dut (
        .clk80       (clk80),
        .rst         (rst),
        .rdEn        (rdEn),
        .rdAddr      (rdAddr),
        .rdFrame     (rdFrame),
        .rdData      (rdData),
        .wrEn        (wrEn),
        .wrDone      (wrDone),
        .wrReady     (wrReady),
        .bankAddr    (bankAddr),
        .bankRdData0 (bankRdData0),
        .bankRdData1 (bankRdData1),
        .bankRE0     (bankRE0),
        .bankRE1     (bankRE1),
        .bankWE0     (bankWE0),
        .bankWE1     (bankWE1),
        .readBank    (readBank),
        .swapPulse   (swapPulse),
        .overrun     (overrun),
        .underrun    (underrun),
        .overrunCnt  (overrunCnt),
        .underrunCnt (underrunCnt)
    );

    // External bank model: synchronous write, one-cycle registered read
    always @(posedge clk80) begin
        if (bankWE0) begin mem0[wr_addr] <= wr_data; we0_n <= we0_n + 1; end
        if (bankWE1) begin mem1[wr_addr] <= wr_data; we1_n <= we1_n + 1; end
        if (bankRE0) bankRdData0 <= mem0[bankAddr];
        if (bankRE1) bankRdData1 <= mem1[bankAddr];
    end

    task automatic do_reset();
        @(negedge clk80);
        rst = 1'b0; rdEn = 1'b0; rdFrame = 1'b0; wrEn = 1'b0; wrDone = 1'b0; rdAddr = '0;
        repeat (3) @(negedge clk80);
        rst = 1'b1;
        @(negedge clk80);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (readBank !== 1'b0) begin errors++; $display("FAIL reset_readBank got %b want 0", readBank); end
        checks++; if (wrReady !== 1'b1) begin errors++; $display("FAIL reset_wrReady got %b want 1", wrReady); end
        checks++; if (swapPulse !== 1'b0) begin errors++; $display("FAIL reset_swapPulse got %b want 0", swapPulse); end
        checks++; if (rdData !== 12'h000) begin errors++; $display("FAIL reset_rdData got %h want 000", rdData); end
        checks++; if ({overrun, underrun} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {overrun, underrun}); end
        checks++; if ({overrunCnt, underrunCnt} !== 16'h0000) begin errors++; $display("FAIL reset_counters got %h want 0000", {overrunCnt, underrunCnt}); end
        wrEn = 1'b1; rdEn = 1'b1; #1;
        checks++; if ({bankWE1, bankWE0} !== 2'b10) begin errors++; $display("FAIL reset_write_steer got %b want 10", {bankWE1, bankWE0}); end
        checks++; if ({bankRE1, bankRE0} !== 2'b01) begin errors++; $display("FAIL reset_read_steer got %b want 01", {bankRE1, bankRE0}); end
        @(negedge clk80);
        wrEn = 1'b0; rdEn = 1'b0;
    endtask

    task automatic test_swap();
        do_reset();
        wrEn = 1'b1; wr_addr = 10'd5; wr_data = 12'hABC;
        @(negedge clk80);
        wrEn = 1'b0; wrDone = 1'b1;
        @(posedge clk80); #1;
        checks++; if (wrReady !== 1'b0) begin errors++; $display("FAIL swap_wrReady_drop got %b want 0", wrReady); end
        @(negedge clk80);
        wrDone = 1'b0; rdFrame = ~rdFrame;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk80); #1;
            checks++; if (swapPulse !== (k == 4)) begin errors++; $display("FAIL swap_pulse_cyc%0d got %b want %b", k, swapPulse, (k == 4)); end
            checks++; if (readBank !== (k >= 5)) begin errors++; $display("FAIL swap_readBank_cyc%0d got %b want %b", k, readBank, (k >= 5)); end
        end
        checks++; if (wrReady !== 1'b1) begin errors++; $display("FAIL swap_wrReady_rise got %b want 1", wrReady); end
        @(negedge clk80);
        wrEn = 1'b1; wr_data = 12'h123; #1;
        checks++; if ({bankWE1, bankWE0} !== 2'b01) begin errors++; $display("FAIL swap_write_steer got %b want 01", {bankWE1, bankWE0}); end
        @(negedge clk80);
        wrEn = 1'b0; rdEn = 1'b1; rdAddr = 10'd5; #1;
        checks++; if ({bankRE1, bankRE0} !== 2'b10) begin errors++; $display("FAIL swap_read_steer got %b want 10", {bankRE1, bankRE0}); end
        @(posedge clk80); #1;
        checks++; if (rdData !== 12'hABC) begin errors++; $display("FAIL swap_read_data got %h want abc", rdData); end
        @(negedge clk80);
        rdEn = 1'b0;
    endtask

    task automatic test_underrun();
        do_reset();
        repeat (2) begin
            rdFrame = ~rdFrame;
            repeat (6) @(negedge clk80);
        end
        checks++; if (underrunCnt !== (STATS ? 8'd2 : 8'd0)) begin errors++; $display("FAIL underrun_count got %0d want %0d", underrunCnt, (STATS ? 2 : 0)); end
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_flag got %b want 1", underrun); end
        checks++; if (readBank !== 1'b0) begin errors++; $display("FAIL underrun_readBank got %b want 0", readBank); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL underrun_no_overrun got %b want 0", overrun); end
    endtask

    task automatic test_overrun();
        int base0, base1;
        do_reset();
        wrDone = 1'b1;
        @(negedge clk80);
        wrDone = 1'b0;
        base0 = we0_n; base1 = we1_n;
        repeat (10) begin
            @(negedge clk80);
            wrEn = 1'b1; wr_addr = 10'd7;
            @(negedge clk80);
            wrEn = 1'b0;
        end
        @(negedge clk80);
        checks++; if ((we0_n - base0) + (we1_n - base1) !== 0) begin errors++; $display("FAIL overrun_dropped_writes got %0d want 0", (we0_n - base0) + (we1_n - base1)); end
        checks++; if (overrunCnt !== (STATS ? 8'd1 : 8'd0)) begin errors++; $display("FAIL overrun_count got %0d want %0d", overrunCnt, (STATS ? 1 : 0)); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b want 1", overrun); end
        checks++; if (wrReady !== 1'b0) begin errors++; $display("FAIL overrun_wrReady got %b want 0", wrReady); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        rdFrame = ~rdFrame;
        repeat (3) @(posedge clk80);
        @(negedge clk80);
        wrDone = 1'b1;
        @(posedge clk80); #1;
        checks++; if (swapPulse !== 1'b1) begin errors++; $display("FAIL same_cycle_swap got %b want 1", swapPulse); end
        @(negedge clk80);
        wrDone = 1'b0;
        @(posedge clk80); #1;
        checks++; if (readBank !== 1'b1) begin errors++; $display("FAIL same_cycle_readBank got %b want 1", readBank); end
        checks++; if ({underrun, underrunCnt} !== 9'd0) begin errors++; $display("FAIL same_cycle_no_underrun got %b/%0d want 0/0", underrun, underrunCnt); end
        checks++; if (wrReady !== 1'b1) begin errors++; $display("FAIL same_cycle_wrReady got %b want 1", wrReady); end
    endtask

    task automatic test_saturate();
        do_reset();
        repeat (300) begin
            rdFrame = ~rdFrame;
            repeat (2) @(negedge clk80);
        end
        repeat (6) @(negedge clk80);
        checks++; if (underrunCnt !== (STATS ? 8'd255 : 8'd0)) begin errors++; $display("FAIL saturate_count got %0d want %0d", underrunCnt, (STATS ? 255 : 0)); end
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL saturate_flag got %b want 1", underrun); end
        checks++; if (readBank !== 1'b0) begin errors++; $display("FAIL saturate_readBank got %b want 0", readBank); end
    endtask

    initial begin
        test_reset();
        test_swap();
        test_underrun();
        test_overrun();
        test_same_cycle();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
